// File: rtl/ex_mem_wb_regs.sv
// EX->MEM and MEM->WB pipeline registers feeding the forwarding mux.
// Inserts load-use bubbles into MEM on Stall and counts them (saturating).
module ex_mem_wb_regs #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             Clk,
  input  logic             RstN,
  input  logic             Halt,
  input  logic             Stall,
  input  logic [5:0]       EXRegisterNumber,
  input  logic             EXWriteEn,
  input  logic [31:0]      EXAluResult,
  input  logic             EXLoad,
  input  logic [31:0]      MemReadData,
  output logic [5:0]       MEMRegisterNumber,
  output logic [31:0]      MEMAluResultData,
  output logic             MEMLoad,
  output logic [5:0]       WBRegisterNumber,
  output logic [31:0]      WBAluResultData,
  output logic [31:0]      WBReadData,
  output logic             WBLoad,
  output logic             WBWriteEn,
  output logic [CNT_W-1:0] BubbleCount
);

  logic [5:0]       mem_num_q,   mem_num_d;
  logic [31:0]      mem_alu_q,   mem_alu_d;
  logic             mem_load_q,  mem_load_d;
  logic [5:0]       wb_num_q,    wb_num_d;
  logic [31:0]      wb_alu_q,    wb_alu_d;
  logic [31:0]      wb_rdata_q,  wb_rdata_d;
  logic             wb_load_q,   wb_load_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

  // Priority: Halt freezes everything; otherwise WB always advances and
  // Stall only chooses between a bubble and the EX instruction for MEM.
  always_comb begin
    mem_num_d    = mem_num_q;
    mem_alu_d    = mem_alu_q;
    mem_load_d   = mem_load_q;
    wb_num_d     = wb_num_q;
    wb_alu_d     = wb_alu_q;
    wb_rdata_d   = wb_rdata_q;
    wb_load_d    = wb_load_q;
    bubble_cnt_d = bubble_cnt_q;
    if (!Halt) begin
      wb_num_d   = mem_num_q;
      wb_alu_d   = mem_alu_q;
      wb_load_d  = mem_load_q;
      wb_rdata_d = mem_load_q ? MemReadData : '0;
      if (Stall) begin
        mem_num_d  = '0;
        mem_alu_d  = '0;
        mem_load_d = 1'b0;
        if (bubble_cnt_q != '1) begin
          bubble_cnt_d = bubble_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end else begin
        mem_num_d  = EXWriteEn ? EXRegisterNumber : '0;
        mem_alu_d  = EXAluResult;
        mem_load_d = EXLoad;
      end
    end
  end

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      mem_num_q    <= '0;
      mem_alu_q    <= '0;
      mem_load_q   <= 1'b0;
      wb_num_q     <= '0;
      wb_alu_q     <= '0;
      wb_rdata_q   <= '0;
      wb_load_q    <= 1'b0;
      bubble_cnt_q <= '0;
    end else begin
      mem_num_q    <= mem_num_d;
      mem_alu_q    <= mem_alu_d;
      mem_load_q   <= mem_load_d;
      wb_num_q     <= wb_num_d;
      wb_alu_q     <= wb_alu_d;
      wb_rdata_q   <= wb_rdata_d;
      wb_load_q    <= wb_load_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign MEMRegisterNumber = mem_num_q;
  assign MEMAluResultData  = mem_alu_q;
  assign MEMLoad           = mem_load_q;
  assign WBRegisterNumber  = wb_num_q;
  assign WBAluResultData   = wb_alu_q;
  assign WBReadData        = wb_rdata_q;
  assign WBLoad            = wb_load_q;
  assign WBWriteEn         = (wb_num_q != '0);
  assign BubbleCount       = bubble_cnt_q;

endmodule

// File: tb/tb_ex_mem_wb_regs.sv
// Bench for ex_mem_wb_regs: stage-level model compared every cycle on two
// instances (CNT_W=16 and CNT_W=4), plus directed literal expectations.
module tb_ex_mem_wb_regs;

  logic        Clk, RstN, Halt, Stall;
  logic [5:0]  ex_num;
  logic        ex_we;
  logic [31:0] ex_alu;
  logic        ex_load;
  logic [31:0] mem_rdata;

  logic [5:0]  a_mnum, b_mnum, a_wnum, b_wnum;
  logic [31:0] a_malu, b_malu, a_walu, b_walu, a_wrd, b_wrd;
  logic        a_mld, b_mld, a_wld, b_wld, a_wwe, b_wwe;
  logic [15:0] a_cnt;
  logic [3:0]  b_cnt;

  int unsigned checks = 0;
  int unsigned errors = 0;
  bit          started = 0;

  ex_mem_wb_regs #(.CNT_W(16)) dut (
    .Clk(Clk), .RstN(RstN), .Halt(Halt), .Stall(Stall),
    .EXRegisterNumber(ex_num), .EXWriteEn(ex_we), .EXAluResult(ex_alu),
    .EXLoad(ex_load), .MemReadData(mem_rdata),
    .MEMRegisterNumber(a_mnum), .MEMAluResultData(a_malu), .MEMLoad(a_mld),
    .WBRegisterNumber(a_wnum), .WBAluResultData(a_walu), .WBReadData(a_wrd),
    .WBLoad(a_wld), .WBWriteEn(a_wwe), .BubbleCount(a_cnt)
  );

  ex_mem_wb_regs #(.CNT_W(4)) dut4 (
    .Clk(Clk), .RstN(RstN), .Halt(Halt), .Stall(Stall),
    .EXRegisterNumber(ex_num), .EXWriteEn(ex_we), .EXAluResult(ex_alu),
    .EXLoad(ex_load), .MemReadData(mem_rdata),
    .MEMRegisterNumber(b_mnum), .MEMAluResultData(b_malu), .MEMLoad(b_mld),
    .WBRegisterNumber(b_wnum), .WBAluResultData(b_walu), .WBReadData(b_wrd),
    .WBLoad(b_wld), .WBWriteEn(b_wwe), .BubbleCount(b_cnt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an instruction is a {dest, alu, load} record moving MEM -> WB.
  typedef struct packed {
    logic [5:0]  num;
    logic [31:0] alu;
    logic        load;
  } instr_t;

  instr_t      m_mem, m_wb;
  logic [31:0] m_rdata;
  int unsigned m_bubbles;

  always @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      m_mem = '0; m_wb = '0; m_rdata = '0; m_bubbles = 0;
    end else if (!Halt) begin
      m_rdata = m_mem.load ? mem_rdata : 32'h0;
      m_wb    = m_mem;
      if (Stall) begin
        m_mem = '0;
        m_bubbles++;
      end else begin
        m_mem = '{num: (ex_we ? ex_num : 6'd0), alu: ex_alu, load: ex_load};
      end
    end
  end

  always @(negedge Clk) begin
    if (started) begin
      chk("mem_num",  {26'd0, a_mnum}, {26'd0, m_mem.num});
      chk("mem_alu",  a_malu,          m_mem.alu);
      chk("mem_load", {31'd0, a_mld},  {31'd0, m_mem.load});
      chk("wb_num",   {26'd0, a_wnum}, {26'd0, m_wb.num});
      chk("wb_alu",   a_walu,          m_wb.alu);
      chk("wb_load",  {31'd0, a_wld},  {31'd0, m_wb.load});
      chk("wb_rdata", a_wrd,           m_rdata);
      chk("wb_we",    {31'd0, a_wwe},  {31'd0, (m_wb.num != 6'd0)});
      chk("cnt16",    {16'd0, a_cnt},  (m_bubbles > 65535) ? 32'd65535 : m_bubbles);
      chk("cnt4",     {28'd0, b_cnt},  (m_bubbles > 15) ? 32'd15 : m_bubbles);
      chk("dut4_same_path", {b_mnum, b_wnum, b_mld, b_wld, b_wwe}, {a_mnum, a_wnum, a_mld, a_wld, a_wwe});
      chk("dut4_wb_alu", b_walu ^ b_wrd ^ b_malu, a_walu ^ a_wrd ^ a_malu);
    end
  end

  task automatic set_ex(input logic [5:0] n, input logic we, input logic [31:0] alu, input logic ld);
    ex_num = n; ex_we = we; ex_alu = alu; ex_load = ld;
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  typedef struct packed {
    logic [5:0]  n;
    logic        we;
    logic [31:0] alu;
    logic        ld;
    logic [31:0] rd;
    logic        st;
    logic        hl;
  } vec_t;

  vec_t vecs [8];

  initial begin
    vecs[0] = '{n: 6'd63, we: 1'b1, alu: 32'hFFFF_FFFF, ld: 1'b1, rd: 32'h0BAD_F00D, st: 1'b0, hl: 1'b0};
    vecs[1] = '{n: 6'd1,  we: 1'b1, alu: 32'h0000_0004, ld: 1'b0, rd: 32'hCAFE_0001, st: 1'b1, hl: 1'b0};
    vecs[2] = '{n: 6'd2,  we: 1'b0, alu: 32'h1111_2222, ld: 1'b1, rd: 32'h5555_AAAA, st: 1'b0, hl: 1'b0};
    vecs[3] = '{n: 6'd40, we: 1'b1, alu: 32'h8000_0000, ld: 1'b1, rd: 32'h1234_5678, st: 1'b0, hl: 1'b1};
    vecs[4] = '{n: 6'd40, we: 1'b1, alu: 32'h8000_0000, ld: 1'b1, rd: 32'h8765_4321, st: 1'b1, hl: 1'b0};
    vecs[5] = '{n: 6'd0,  we: 1'b1, alu: 32'h0000_0010, ld: 1'b0, rd: 32'h0000_0000, st: 1'b0, hl: 1'b0};
    vecs[6] = '{n: 6'd17, we: 1'b1, alu: 32'hA5A5_5A5A, ld: 1'b0, rd: 32'hFEED_FACE, st: 1'b0, hl: 1'b0};
    vecs[7] = '{n: 6'd18, we: 1'b1, alu: 32'h0000_0001, ld: 1'b1, rd: 32'h0000_0002, st: 1'b0, hl: 1'b0};

    // Reset asserted with busy inputs: outputs must read zero before any edge.
    RstN = 1'b0; Halt = 1'b0; Stall = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    set_ex(6'd33, 1'b1, 32'hDEAD_0000, 1'b1);
    #2;
    started = 1;
    chk("rst_mem_num", {26'd0, a_mnum}, 32'd0);
    chk("rst_wb_we",   {31'd0, a_wwe},  32'd0);
    chk("rst_cnt",     {16'd0, a_cnt},  32'd0);
    step(); step();
    RstN = 1'b1; Stall = 1'b0;

    // Pipeline flow
    set_ex(6'd5, 1'b1, 32'h1234, 1'b0);
    step();
    chk("flow_mem_num", {26'd0, a_mnum}, 32'd5);
    chk("flow_mem_alu", a_malu, 32'h1234);
    set_ex(6'd9, 1'b0, 32'hAAAA, 1'b0);
    step();
    chk("flow_wb_num",   {26'd0, a_wnum}, 32'd5);
    chk("flow_wb_we",    {31'd0, a_wwe},  32'd1);
    chk("flow_wb_rdata", a_wrd, 32'd0);
    chk("nowrite_mem_num", {26'd0, a_mnum}, 32'd0);
    set_ex(6'd3, 1'b1, 32'h100, 1'b1);
    step();
    chk("nowrite_wb_we", {31'd0, a_wwe}, 32'd0);
    chk("load_mem_num",  {26'd0, a_mnum}, 32'd3);
    chk("load_mem_ld",   {31'd0, a_mld},  32'd1);

    // Load-use bubble
    mem_rdata = 32'hDEADBEEF; Stall = 1'b1;
    set_ex(6'd7, 1'b1, 32'h777, 1'b0);
    step();
    chk("lu_mem_bubble", {a_mnum, a_malu, a_mld}, 39'd0);
    chk("lu_wb_num",   {26'd0, a_wnum}, 32'd3);
    chk("lu_wb_load",  {31'd0, a_wld},  32'd1);
    chk("lu_wb_rdata", a_wrd, 32'hDEADBEEF);
    chk("lu_cnt",      {16'd0, a_cnt},  32'd1);
    Stall = 1'b0;
    step();
    chk("resume_mem_num", {26'd0, a_mnum}, 32'd7);
    chk("resume_wb_num",  {26'd0, a_wnum}, 32'd0);

    // Halt beats Stall
    Halt = 1'b1; Stall = 1'b1;
    set_ex(6'd11, 1'b1, 32'hBBB, 1'b1);
    for (int i = 0; i < 3; i++) step();
    chk("halt_mem_num", {26'd0, a_mnum}, 32'd7);
    chk("halt_mem_alu", a_malu, 32'h777);
    chk("halt_wb_num",  {26'd0, a_wnum}, 32'd0);
    chk("halt_cnt",     {16'd0, a_cnt},  32'd1);
    Halt = 1'b0; Stall = 1'b0;
    step();
    chk("unhalt_mem_num", {26'd0, a_mnum}, 32'd11);
    chk("unhalt_wb_num",  {26'd0, a_wnum}, 32'd7);
    chk("unhalt_wb_alu",  a_walu, 32'h777);

    // Mid-cycle asynchronous reset drops the in-flight write at once
    RstN = 1'b0;
    #1;
    chk("mid_rst_wb_we",   {31'd0, a_wwe}, 32'd0);
    chk("mid_rst_mem_num", {26'd0, a_mnum}, 32'd0);
    chk("mid_rst_cnt",     {16'd0, a_cnt}, 32'd0);
    step();
    RstN = 1'b1;

    // Saturation on the 4-bit counter
    Stall = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      chk("sat_cnt4",  {28'd0, b_cnt}, (k < 15) ? k : 15);
      chk("sat_cnt16", {16'd0, a_cnt}, k);
    end
    Stall = 1'b0;

    // Mixed directed vectors, checked by the per-cycle model
    foreach (vecs[i]) begin
      set_ex(vecs[i].n, vecs[i].we, vecs[i].alu, vecs[i].ld);
      mem_rdata = vecs[i].rd; Stall = vecs[i].st; Halt = vecs[i].hl;
      step();
    end
    Halt = 1'b0; Stall = 1'b0;
    step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
